// File: rtl/drive_strobe_decoder_pkg.sv
// Shared definitions for the drive-strobe decoder slice.
//   CODE_W  : width of the binary source code
//   DATA_W  : width of the one-hot drive-enable vector
//   CNT_W   : width of the pulse/gap down-counter
//   state_e : controller states
package drive_strobe_decoder_pkg;

   localparam int CODE_W = 3;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/drive_strobe_decoder_decode_3_8.sv
// Purely combinational binary-to-one-hot decoder; the inverse of the 8-to-3
// encoder used on the bus side.
//   code_i   : binary index
//   onehot_o : one-hot vector with bit code_i set
module decode_3_8
   import drive_strobe_decoder_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   output logic [DATA_W-1:0] onehot_o
);

   always_comb begin
      onehot_o         = '0;
      onehot_o[code_i] = 1'b1;
   end

endmodule

// File: rtl/drive_strobe_decoder.sv
// Registered 3-to-8 decoder for bus-drive enables with break-before-make.
// An accepted Code drives its one-hot enable for PULSE_CYCLES cycles (longer
// while Hold is high at the end of the pulse), followed by GAP_CYCLES of
// all-zero output before the next Code can be accepted.
//   clk   : rising-edge clock
//   clr   : synchronous active-low reset
//   Code  : binary index of the source to enable
//   Valid : Code is presented
//   Ready : block can accept Code this cycle (decoded from state and clr)
//   Hold  : extends the current pulse while high
//   Data  : registered one-hot drive enables
//   Busy  : registered, high in DRIVE or GAP
//   Done  : registered single-cycle pulse when a drive ends
module drive_strobe_decoder
   import drive_strobe_decoder_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = 1,
   parameter int unsigned GAP_CYCLES   = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [CODE_W-1:0] Code,
   input  logic              Valid,
   output logic              Ready,
   input  logic              Hold,
   output logic [DATA_W-1:0] Data,
   output logic              Busy,
   output logic              Done
);

   if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15) begin : g_bad_pulse
      $error("drive_strobe_decoder: PULSE_CYCLES must be in 1..15");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
      $error("drive_strobe_decoder: GAP_CYCLES must be in 1..15");
   end

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [CODE_W-1:0]   code_q,  code_d;
   logic [DATA_W-1:0]   data_q,  data_d;
   logic                busy_q,  busy_d;
   logic                done_q,  done_d;
   logic [DATA_W-1:0]   onehot;

   assign Ready = clr & (state_q == S_IDLE);

   // Decoding the next latched code lets Data be valid from the accept edge.
   decode_3_8 u_decode (
      .code_i   (code_d),
      .onehot_o (onehot)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (Valid && Ready) begin
               state_d = S_DRIVE;
               cnt_d   = PULSE_LD;
               code_d  = Code;
            end
         end
         S_DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!Hold) begin
               state_d = S_GAP;
               cnt_d   = GAP_LD;
               done_d  = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      data_d = (state_d == S_DRIVE) ? onehot : '0;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Data = data_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_drive_strobe_decoder.sv
module tb_drive_strobe_decoder;

   logic       clk = 1'b0;
   logic       clr;
   logic [2:0] Code;
   logic       Valid;
   logic       Hold;

   logic       Ready,  Busy,  Done;
   logic [7:0] Data;
   logic       Ready2, Busy2, Done2;
   logic [7:0] Data2;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   drive_strobe_decoder dut (
      .clk   (clk),
      .clr   (clr),
      .Code  (Code),
      .Valid (Valid),
      .Ready (Ready),
      .Hold  (Hold),
      .Data  (Data),
      .Busy  (Busy),
      .Done  (Done)
   );

   drive_strobe_decoder #(
      .PULSE_CYCLES (2),
      .GAP_CYCLES   (2)
   ) dut2 (
      .clk   (clk),
      .clr   (clr),
      .Code  (Code),
      .Valid (Valid),
      .Ready (Ready2),
      .Hold  (Hold),
      .Data  (Data2),
      .Busy  (Busy2),
      .Done  (Done2)
   );

   // Bus-side 8-to-3 encoder used for loopback.
   function automatic logic [2:0] enc8to3(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) r = 3'(i);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with a code presented: nothing may be accepted.
      clr   = 1'b0;
      Valid = 1'b1;
      Code  = 3'd5;
      Hold  = 1'b0;
      #1;
      check("rst_ready_pre", Ready, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_data",  Data,  0);
         check("rst_busy",  Busy,  0);
         check("rst_done",  Done,  0);
         check("rst_ready", Ready, 0);
      end
      clr   = 1'b1;
      Valid = 1'b0;
      #1;
      check("rel_ready", Ready, 1);
      tick();
      check("rel_data", Data, 0);
      check("rel_busy", Busy, 0);

      // Single accept, PULSE=1 GAP=1.
      Code  = 3'd3;
      Valid = 1'b1;
      tick();
      Valid = 1'b0;
      check("one_data",  Data,  8'b0000_1000);
      check("one_busy",  Busy,  1);
      check("one_ready", Ready, 0);
      check("one_done0", Done,  0);
      tick();
      check("one_gap_data", Data,  0);
      check("one_gap_done", Done,  1);
      check("one_gap_busy", Busy,  1);
      check("one_gap_rdy",  Ready, 0);
      tick();
      check("one_idle_data", Data,  0);
      check("one_idle_done", Done,  0);
      check("one_idle_busy", Busy,  0);
      check("one_idle_rdy",  Ready, 1);

      // Hold extension: Hold high at four end-of-pulse edges.
      Code  = 3'd6;
      Valid = 1'b1;
      tick();
      Valid = 1'b0;
      Hold  = 1'b1;
      check("hold_data0", Data, 8'b0100_0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_data", Data, 8'b0100_0000);
         check("hold_done", Done, 0);
      end
      Hold = 1'b0;
      tick();
      check("hold_end_data", Data, 0);
      check("hold_end_done", Done, 1);
      tick();
      check("hold_idle_done", Done,  0);
      check("hold_idle_busy", Busy,  0);
      check("hold_idle_rdy",  Ready, 1);

      // Inputs changed while busy are ignored.
      Code  = 3'd2;
      Valid = 1'b1;
      tick();
      Code  = 3'd7;
      Valid = 1'b0;
      check("ign_data", Data,  8'h04);
      check("ign_rdy",  Ready, 0);
      tick();
      Valid = 1'b1;
      check("ign_gap_data", Data,  0);
      check("ign_gap_rdy",  Ready, 0);
      tick();
      check("ign_idle_data", Data,  0);
      check("ign_idle_rdy",  Ready, 1);
      tick();
      Valid = 1'b0;
      check("ign_code7", Data, 8'h80);
      tick();
      tick();
      check("ign_back_idle", Ready, 1);

      // Reset during a drive: Data drops, no Done.
      Code  = 3'd1;
      Valid = 1'b1;
      tick();
      Valid = 1'b0;
      check("mid_data", Data, 8'h02);
      clr = 1'b0;
      #1;
      check("mid_rdy_clr", Ready, 0);
      tick();
      check("mid_rst_data", Data, 0);
      check("mid_rst_done", Done, 0);
      check("mid_rst_busy", Busy, 0);
      clr = 1'b1;
      #1;
      check("mid_rel_rdy", Ready, 1);
      tick();
      check("mid_post_done", Done, 0);
      check("mid_post_data", Data, 0);

      // Sweep on the PULSE=2 GAP=2 instance, Valid held high.
      clr = 1'b0;
      tick();
      clr   = 1'b1;
      Valid = 1'b1;
      Code  = 3'd0;
      #1;
      check("sw_start_rdy", Ready2, 1);
      for (int k = 0; k < 8; k++) begin
         logic [7:0] exp_oh;
         exp_oh = 8'd1 << k;
         tick();
         check("sw_data_a", Data2, exp_oh);
         check("sw_loop",   enc8to3(Data2), k);
         tick();
         check("sw_data_b", Data2, exp_oh);
         check("sw_done_b", Done2, 0);
         tick();
         check("sw_gap1",   Data2, 0);
         check("sw_done",   Done2, 1);
         tick();
         check("sw_gap2",   Data2, 0);
         check("sw_done2",  Done2, 0);
         check("sw_rdy_lo", Ready2, 0);
         tick();
         check("sw_idle",   Data2, 0);
         check("sw_rdy",    Ready2, 1);
         Code = 3'(k + 1);
      end
      Valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
